// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: unpacks a framed byte stream into 19-bit words.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 14,
  parameter int WORD_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we_IM,
  output logic [WORD_W-1:0] codein,
  output logic [ADDR_W-1:0] immd,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_HDR0  = 4'd1,
    ST_HDR1  = 4'd2,
    ST_DATA0 = 4'd3,
    ST_DATA1 = 4'd4,
    ST_DATA2 = 4'd5,
    ST_WRITE = 4'd6,
    ST_CHK   = 4'd7,
    ST_DONE  = 4'd8,
    ST_ERR   = 4'd9
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LAST_ST = ST_CHK;
`else
  localparam state_t LAST_ST = ST_DONE;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_t            state_r;
  state_t            state_nx_s;
  logic              byte_acc_s;
  logic              start_clr_s;
  logic [5:0]        cnt_h_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [2:0]        b0_r;
  logic [7:0]        b1_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_r;
`endif

  function automatic logic ready_in(input state_t s);
    case (s)
      ST_HDR0, ST_HDR1, ST_DATA0, ST_DATA1, ST_DATA2, ST_CHK: ready_in = 1'b1;
      default:                                               ready_in = 1'b0;
    endcase
  endfunction

  function automatic logic busy_in(input state_t s);
    case (s)
      ST_IDLE, ST_DONE, ST_ERR: busy_in = 1'b0;
      default:                  busy_in = 1'b1;
    endcase
  endfunction

  assign byte_acc_s  = rx_valid && rx_ready;
  // HDR0 is only ever entered from a start, so that transition clears per-load state
  assign start_clr_s = (state_nx_s == ST_HDR0) && (state_r != ST_HDR0);

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_nx_s = ST_HDR0;
        else       state_nx_s = state_r;
      end
      ST_HDR0: begin
        if (!byte_acc_s)               state_nx_s = state_r;
        else if (rx_data[7:6] != 2'b00) state_nx_s = ST_ERR;
        else                           state_nx_s = ST_HDR1;
      end
      ST_HDR1: begin
        if (!byte_acc_s)                            state_nx_s = state_r;
        else if ({cnt_h_r, rx_data} == ADDR_ZERO)  state_nx_s = LAST_ST;
        else                                        state_nx_s = ST_DATA0;
      end
      ST_DATA0: begin
        if (!byte_acc_s)                   state_nx_s = state_r;
        else if (rx_data[7:3] != 5'b00000) state_nx_s = ST_ERR;
        else                               state_nx_s = ST_DATA1;
      end
      ST_DATA1: begin
        if (byte_acc_s) state_nx_s = ST_DATA2;
        else            state_nx_s = state_r;
      end
      ST_DATA2: begin
        if (byte_acc_s) state_nx_s = ST_WRITE;
        else            state_nx_s = state_r;
      end
      ST_WRITE: begin
        if ((immd + ADDR_ONE) == cnt_r) state_nx_s = LAST_ST;
        else                            state_nx_s = ST_DATA0;
      end
      ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!byte_acc_s)           state_nx_s = state_r;
        else if (rx_data == chk_r) state_nx_s = ST_DONE;
        else                       state_nx_s = ST_ERR;
`else
        state_nx_s = ST_ERR;
`endif
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, registered outputs and datapath capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rx_ready <= 1'b0;
      we_IM    <= 1'b0;
      codein   <= {WORD_W{1'b0}};
      immd     <= ADDR_ZERO;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt_h_r  <= 6'd0;
      cnt_r    <= ADDR_ZERO;
      b0_r     <= 3'd0;
      b1_r     <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_r    <= 8'h00;
`endif
    end else begin
      state_r  <= state_nx_s;
      rx_ready <= ready_in(state_nx_s);
      busy     <= busy_in(state_nx_s);
      we_IM    <= (state_nx_s == ST_WRITE);
      en       <= (state_nx_s == ST_DONE);
      done     <= (state_nx_s == ST_DONE);
      err      <= (state_nx_s == ST_ERR);

      if (start_clr_s)             immd <= ADDR_ZERO;
      else if (state_r == ST_WRITE) immd <= immd + ADDR_ONE;

      if (byte_acc_s) begin
        case (state_r)
          ST_HDR0:  cnt_h_r <= rx_data[5:0];
          ST_HDR1:  cnt_r   <= {cnt_h_r, rx_data};
          ST_DATA0: b0_r    <= rx_data[2:0];
          ST_DATA1: b1_r    <= rx_data;
          ST_DATA2: codein  <= {b0_r, b1_r, rx_data};
          default:  ;
        endcase
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (start_clr_s)                           chk_r <= 8'h00;
      else if (byte_acc_s && state_r != ST_CHK)  chk_r <= chk_r ^ rx_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus and
// popped by an independent monitor whenever we_IM is seen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we_IM;
  logic [18:0] codein;
  logic [13:0] immd;
  logic        en;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we_IM(we_IM), .codein(codein), .immd(immd),
    .en(en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int LAT = 2;
  localparam int CHK_BYTES = 1;
`else
  localparam int LAT = 1;
  localparam int CHK_BYTES = 0;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          done_cyc = 0;
  logic        done_q = 1'b0;
  logic [32:0] exp_q[$];
  int          wr_cyc[$];
  logic [7:0]  frame[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each write strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) acc_cnt++;
      if (done && !done_q) done_cyc = cyc;
      done_q = done;
      if (we_IM) begin
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(immd), 32'hFFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("write_addr", 32'(immd), 32'(e[32:19]));
          check("write_word", 32'(codein), 32'(e[18:0]));
        end
      end
    end else begin
      done_q = 1'b0;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      check("byte_accept_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_frame(input bit gap, input bit add_chk);
    logic [7:0] x;
    x = 8'h00;
    foreach (frame[i]) begin
      x = x ^ frame[i];
      send_byte(frame[i], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (add_chk) send_byte(x, gap);
`else
    if (add_chk) x = 8'h00;
`endif
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("end_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outs(input string nm);
    check({nm, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({nm, "_we_IM"},    32'(we_IM),    32'd0);
    check({nm, "_codein"},   32'(codein),   32'd0);
    check({nm, "_immd"},     32'(immd),     32'd0);
    check({nm, "_en"},       32'(en),       32'd0);
    check({nm, "_busy"},     32'(busy),     32'd0);
    check({nm, "_done"},     32'(done),     32'd0);
    check({nm, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Two words, valid held high
    frame = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h00, 8'h01};
    exp_q.push_back({14'd0, 19'h12345});
    exp_q.push_back({14'd1, 19'h60001});
    wr_cyc.delete();
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    send_frame(1'b0, 1'b1);
    wait_end();
    check("t1_done", 32'(done), 32'd1);
    check("t1_en", 32'(en), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_queue_left", 32'(exp_q.size()), 32'd0);
    check("t1_writes", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() >= 2) begin
      check("t1_word_cycles", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
      check("t1_en_latency", 32'(done_cyc - wr_cyc[1]), 32'(LAT));
    end

    // Empty image
    frame = '{8'h00, 8'h00};
    wr_cyc.delete();
    pulse_start();
    check("restart_clears_en", 32'(en), 32'd0);
    send_frame(1'b0, 1'b1);
    wait_end();
    check("n0_done", 32'(done), 32'd1);
    check("n0_en", 32'(en), 32'd1);
    check("n0_writes", 32'(wr_cyc.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    frame = '{8'h00, 8'h00, 8'h01};
    pulse_start();
    send_frame(1'b0, 1'b0);
    wait_end();
    check("n0_badchk_err", 32'(err), 32'd1);
    check("n0_badchk_en", 32'(en), 32'd0);
`endif

    // Count high bits set
    frame = '{8'h40};
    wr_cyc.delete();
    pulse_start();
    send_frame(1'b0, 1'b0);
    wait_end();
    check("cnth_err", 32'(err), 32'd1);
    check("cnth_en", 32'(en), 32'd0);
    check("cnth_done", 32'(done), 32'd0);
    check("cnth_writes", 32'(wr_cyc.size()), 32'd0);
    pulse_start();
    check("start_clears_err", 32'(err), 32'd0);
    check("start_sets_busy", 32'(busy), 32'd1);
    frame = '{8'h00, 8'h00};
    send_frame(1'b0, 1'b1);
    wait_end();
    check("recover_done", 32'(done), 32'd1);

    // Bad B0 in second word
    frame = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h08};
    exp_q.push_back({14'd0, 19'h12345});
    wr_cyc.delete();
    pulse_start();
    send_frame(1'b0, 1'b0);
    wait_end();
    check("b0_err", 32'(err), 32'd1);
    check("b0_en", 32'(en), 32'd0);
    check("b0_writes", 32'(wr_cyc.size()), 32'd1);
    check("b0_queue_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: one idle-valid cycle after every byte
    frame = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h06, 8'h00, 8'h01};
    exp_q.push_back({14'd0, 19'h12345});
    exp_q.push_back({14'd1, 19'h60001});
    wr_cyc.delete();
    pulse_start();
    acc_cnt = 0;
    send_frame(1'b1, 1'b1);
    wait_end();
    check("bp_done", 32'(done), 32'd1);
    check("bp_accepted", 32'(acc_cnt), 32'(8 + CHK_BYTES));
    check("bp_writes", 32'(wr_cyc.size()), 32'd2);
    check("bp_queue_left", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in DATA1
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_outs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    frame = '{8'h00, 8'h01, 8'h01, 8'h23, 8'h45};
    exp_q.push_back({14'd0, 19'h12345});
    wr_cyc.delete();
    pulse_start();
    send_frame(1'b0, 1'b1);
    wait_end();
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_writes", 32'(wr_cyc.size()), 32'd1);
    check("post_rst_queue_left", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum (correct would be 0x66)
    frame = '{8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'hFF};
    exp_q.push_back({14'd0, 19'h12345});
    wr_cyc.delete();
    pulse_start();
    send_frame(1'b0, 1'b0);
    wait_end();
    check("chk_err", 32'(err), 32'd1);
    check("chk_en", 32'(en), 32'd0);
    check("chk_writes", 32'(wr_cyc.size()), 32'd1);
    pulse_start();
    check("chk_start_clears_err", 32'(err), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
